// File: rtl/mcycle_unit.sv
// mcycle_unit
//   Iterative multiply/divide unit that sits beside the single-cycle ALU in the
//   Execute stage. It handles RV32M mul/mulh/mulhu/div/divu/rem/remu by working
//   on operand magnitudes, one bit per cycle, and applying a sign fix-up at the
//   end. Timing is fixed at WIDTH compute cycles for every operation, including
//   a divide by zero.
//
// Ports
//   CLK       clock, rising edge
//   RESET     asynchronous active-high reset
//   Start     operation request, only looked at in IDLE
//   MCycleOp  00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div
//   Operand1  multiplicand / dividend
//   Operand2  multiplier / divisor
//   Result1   low product word / quotient (registered)
//   Result2   high product word / remainder (registered)
//   Busy      combinational stall request
//   Done      one-cycle pulse, results valid in this cycle
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      count_reg;
    logic [1:0]         op_reg;
    logic               sign1_reg, sign2_reg;
    logic               div_zero_reg;
    logic [WIDTH-1:0]   mag1_reg, mag2_reg;
    // Product accumulator for multiply; the low half doubles as the quotient
    // shift register for divide.
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH:0]     rem_reg;
    logic [WIDTH-1:0]   result1_reg, result2_reg;

    // Operand signs are only meaningful for the signed variants (bit 0 clear).
    logic in_sign1, in_sign2;
    assign in_sign1 = ~MCycleOp[0] & Operand1[WIDTH-1];
    assign in_sign2 = ~MCycleOp[0] & Operand2[WIDTH-1];

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Start) state_next = COMPUTE;
            COMPUTE: if (count_reg == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // ---------------- one iteration of the datapath ----------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic               div_bit;
    logic [WIDTH+1:0]   rem_shift, rem_diff;
    logic               fits;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;

    always_comb begin
        // Shift-add: multiplier bits consumed LSB first, accumulator shifts right.
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                 + (mag2_reg[count_reg] ? {1'b0, mag1_reg} : '0);
        mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

        // Restoring divide: dividend bits consumed MSB first. The difference
        // is one bit wider than the remainder so its top bit is a clean sign.
        div_bit   = mag1_reg[LAST - count_reg];
        rem_shift = {rem_reg, div_bit};
        rem_diff  = rem_shift - {2'b00, mag2_reg};
        fits      = ~rem_diff[WIDTH+1];
        rem_next  = fits ? rem_diff[WIDTH:0] : rem_shift[WIDTH:0];
        quo_next  = {acc_reg[WIDTH-2:0], fits};

        // Sign fix-up on the final iteration's values. A zero divisor leaves
        // the magnitude remainder equal to |Operand1|, so restoring the
        // dividend sign hands back Operand1 unchanged; only the quotient
        // needs forcing to all ones.
        prod_fixed = (~op_reg[0] & (sign1_reg ^ sign2_reg)) ? -mul_next : mul_next;
        quo_fixed  = div_zero_reg ? '1
                   : ((sign1_reg ^ sign2_reg) ? -quo_next : quo_next);
        rem_fixed  = sign1_reg ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_reg    <= '0;
            op_reg       <= '0;
            sign1_reg    <= 1'b0;
            sign2_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            mag1_reg     <= '0;
            mag2_reg     <= '0;
            acc_reg      <= '0;
            rem_reg      <= '0;
            result1_reg  <= '0;
            result2_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        op_reg       <= MCycleOp;
                        sign1_reg    <= in_sign1;
                        sign2_reg    <= in_sign2;
                        mag1_reg     <= in_sign1 ? -Operand1 : Operand1;
                        mag2_reg     <= in_sign2 ? -Operand2 : Operand2;
                        div_zero_reg <= (Operand2 == '0);
                        count_reg    <= '0;
                        acc_reg      <= '0;
                        rem_reg      <= '0;
                    end
                end
                COMPUTE: begin
                    count_reg <= count_reg + 1'b1;
                    if (op_reg[1]) begin
                        acc_reg <= {{WIDTH{1'b0}}, quo_next};
                        rem_reg <= rem_next;
                    end else begin
                        acc_reg <= mul_next;
                    end
                    if (count_reg == LAST) begin
                        result1_reg <= op_reg[1] ? quo_fixed : prod_fixed[WIDTH-1:0];
                        result2_reg <= op_reg[1] ? rem_fixed : prod_fixed[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy    = (state_reg == COMPUTE) | ((state_reg == IDLE) & Start);
    assign Done    = (state_reg == DONE);
    assign Result1 = result1_reg;
    assign Result2 = result2_reg;

endmodule

// File: doc/mcycle_unit.md
# mcycle_unit

Iterative multi-cycle multiply/divide unit in the Execute stage, beside the single-cycle ALU. It takes the same forwarded Src_A and Src_B operands as the ALU and supports RV32M mul/mulh/mulhu/div/divu/rem/remu. Its result feeds the Execute-stage result mux. A combinational Busy output stalls the pipeline while an operation is in flight.

## Interface
- WIDTH, 32: operand and result width; the iteration count equals WIDTH.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- Start  in  1  request an operation; sampled only in IDLE.
- MCycleOp  in  2  operation select:
  - 00: signed multiply
  - 01: unsigned multiply
  - 10: signed divide
  - 11: unsigned divide
- Operand1  in  WIDTH  multiplicand or dividend (Src_A).
- Operand2  in  WIDTH  multiplier or divisor (Src_B).
- Result1  out  WIDTH  low product word (mul) or quotient (div/divu).
- Result2  out  WIDTH  high product word (mulh/mulhu) or remainder (rem/remu).
- Busy  out  1  stall request to the hazard unit.
- Done  out  1  one-cycle pulse; Result1 and Result2 are valid in this cycle.

## Operation
- Clock and reset: one clock, CLK. Reset is asynchronous and active-high, RESET.
- States: IDLE, COMPUTE, DONE.
  - IDLE with Start=1: latch the operation, go to COMPUTE.
  - COMPUTE: stay until the counter reaches WIDTH-1, then go to DONE.
  - DONE: always go to IDLE on the next edge.
- Latch at Start in IDLE:
  - MCycleOp, the operand signs, and the magnitudes of both operands.
  - For signed ops, the magnitude is the two's-complement absolute value, held in WIDTH bits as unsigned. |-2^31| = 0x80000000.
  - Clear the 5-bit iteration counter and the 2*WIDTH-bit shift register.
- Operand1, Operand2 and MCycleOp are ignored outside the Start cycle in IDLE.
- Multiply: radix-2 shift-add over WIDTH iterations on the magnitudes, giving a 2*WIDTH-bit unsigned product.
- Divide: restoring division over WIDTH iterations, one quotient bit per cycle.
  - The partial remainder register is WIDTH+1 bits.
- Sign fix-up, applied when entering DONE:
  - Product is negated if sign1 ^ sign2 (signed mul only).
  - Quotient is negated if sign1 ^ sign2.
  - Remainder takes the sign of the dividend.
- Divide by zero (Operand2 == 0), for both signed and unsigned:
  - Result1 = 0xFFFFFFFF, Result2 = Operand1 unchanged.
  - The zero divisor is detected at Start. The FSM still spends the full COMPUTE duration so timing stays fixed.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives Result1 = 0x80000000, Result2 = 0. This falls out of the magnitude method and needs no special case.
- Result1 and Result2 are registered.
  - Updated only on the edge entering DONE.
  - Held until the next operation completes.
- Start is ignored in COMPUTE and in DONE. A held Start from the stalled instruction must not retrigger in DONE.

## Timing
- Busy = (state==COMPUTE) | (state==IDLE & Start). It is combinational, so the stall takes effect in the Start cycle itself.
- Cycle numbering (cycle 0 = Start seen in IDLE):
  - Busy=1 in cycles 0 to WIDTH (33 cycles for WIDTH=32).
  - Cycle WIDTH+1 is DONE: Busy=0, Done=1, results valid.
  - Cycle WIDTH+2 is IDLE; a new Start is accepted.
- Back-to-back operations: minimum 34 cycles from Start to Done, and 35 cycles between consecutive Starts.
- Reset values: state=IDLE, counter=0, Busy=0 (given Start=0), Done=0, Result1=0, Result2=0.
- Reset mid-COMPUTE: returns to IDLE immediately, abandons the operation, and does not update results from it.
- A Start held high through DONE does not launch a second operation. A Start high in the cycle after DONE (the next instruction) does.

## Test plan
- mulu 0xFFFFFFFF × 0xFFFFFFFF:
  - Busy high for 33 cycles.
  - Done in cycle 33 with Result1=0x00000001, Result2=0xFFFFFFFE.
- mul signed -7 × 3: Result1=0xFFFFFFEB, Result2=0xFFFFFFFF.
- div signed:
  - -7 / 2 gives Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF gives Result1=0x80000000, Result2=0.
- divu 100 / 0: Result1=0xFFFFFFFF, Result2=100, with identical Busy/Done timing. Repeat as a signed divide of -5 / 0: Result2=0xFFFFFFFB.
- Start held high through DONE with the operands changed during COMPUTE:
  - Results reflect the operands latched at Start.
  - Exactly one Done pulse.
  - Busy low in DONE and in the following IDLE cycle.
- RESET asserted at cycle 10 of a divide:
  - Busy and Done drop asynchronously; results stay 0.
  - After release, a new Start completes normally with correct values.
